// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helpers for the instruction cache.
package icache_pkg;

    localparam int AddrLen        = 32;
    localparam int InstLen        = 32;
    localparam int ICacheIndexLen = 7;
    localparam int ICacheTagLen   = 9;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ICacheIdle = 1'b0,
        ICacheMiss = 1'b1
    } icache_state_e;

    // The top quarter of the 18-bit physical window is I/O space and never cached.
    function automatic logic is_uncacheable(input logic [1:0] addr_17_16);
        return addr_17_16 == 2'b11;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read port, clocked write port,
// valid bits cleared by reset while tag and data contents are left alone.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexLen,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [InstLen-1:0]    rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [InstLen-1:0]    wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [InstLen-1:0]  data_q [LINES];

    // Valid bits: cleared asynchronously, set when a line is filled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents: written on fill only, no reset needed since valid guards them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between ifetch and mem_ctrl.
// Hits answer one cycle after acceptance; misses issue a single-word refill.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexLen,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                failed,
    input  logic                if_request,
    input  logic [AddrLen-1:0]  if_addr,
    output logic [InstLen-1:0]  if_inst,
    output logic                if_enable,
    output logic                mc_request,
    output logic [AddrLen-1:0]  mc_addr,
    input  logic [InstLen-1:0]  mc_inst,
    input  logic                mc_enable
);

    localparam int TAG_LO = INDEX_BITS + 2;
    localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

    icache_state_e      state_q;
    logic               if_enable_q;
    logic [InstLen-1:0] if_inst_q;
    logic               mc_request_q;
    logic [AddrLen-1:0] mc_addr_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [InstLen-1:0]    line_data;
    logic                  accept;
    logic                  hit;
    logic                  fill_we;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  unused_addr_bits;

    assign req_idx = if_addr[INDEX_BITS+1:2];
    assign req_tag = if_addr[TAG_HI:TAG_LO];

    // The cycle that carries a response must not re-accept the still-held request.
    assign accept = if_request && !if_enable_q;
    assign hit    = line_valid && (line_tag == req_tag) && !is_uncacheable(if_addr[17:16]);

    // The refill target is recovered from the latched refill address.
    assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
    assign fill_tag = mc_addr_q[TAG_HI:TAG_LO];
    // A flush does not block the fill: the returned word is still good data.
    assign fill_we  = rdy && (state_q == ICacheMiss) && mc_enable
                      && !is_uncacheable(mc_addr_q[17:16]);

    assign unused_addr_bits = ^if_addr[1:0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (req_idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .we_i       (fill_we),
        .wr_idx_i   (fill_idx),
        .wr_tag_i   (fill_tag),
        .wr_data_i  (mc_inst)
    );

    // Controller: IDLE serves hits or launches a refill, MISS waits for mem_ctrl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ICacheIdle;
            if_enable_q  <= 1'b0;
            if_inst_q    <= ZERO_WORD;
            mc_request_q <= 1'b0;
            mc_addr_q    <= '0;
        end else if (rdy) begin
            if (failed) begin
                state_q      <= ICacheIdle;
                if_enable_q  <= 1'b0;
                mc_request_q <= 1'b0;
            end else begin
                case (state_q)
                    ICacheIdle: begin
                        if_enable_q <= 1'b0;
                        if (accept) begin
                            if (hit) begin
                                if_inst_q   <= line_data;
                                if_enable_q <= 1'b1;
                            end else begin
                                mc_addr_q    <= {if_addr[AddrLen-1:2], 2'b00};
                                mc_request_q <= 1'b1;
                                state_q      <= ICacheMiss;
                            end
                        end
                    end
                    ICacheMiss: begin
                        if_enable_q <= 1'b0;
                        if (mc_enable) begin
                            if_inst_q    <= mc_inst;
                            if_enable_q  <= 1'b1;
                            mc_request_q <= 1'b0;
                            state_q      <= ICacheIdle;
                        end
                    end
                    default: state_q <= ICacheIdle;
                endcase
            end
        end
    end

    assign if_inst    = if_inst_q;
    assign if_enable  = if_enable_q;
    assign mc_request = mc_request_q;
    assign mc_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: the bench plays ifetch and mem_ctrl, and a reference
// model tracks which word address each line holds and the word stored there.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        failed;
    logic        if_request;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_enable;
    logic        mc_request;
    logic [31:0] mc_addr;
    logic [31:0] mc_inst;
    logic        mc_enable;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: line index -> word address (addr[17:2]) it holds, and its word.
    logic [15:0] m_line [int];
    logic [31:0] m_word [int];

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .failed     (failed),
        .if_request (if_request),
        .if_addr    (if_addr),
        .if_inst    (if_inst),
        .if_enable  (if_enable),
        .mc_request (mc_request),
        .mc_addr    (mc_addr),
        .mc_inst    (mc_inst),
        .mc_enable  (mc_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int l = line_of(a);
        return !is_io(a) && m_line.exists(l) && (m_line[l] == a[17:2]);
    endfunction

    // One complete fetch starting at a negedge; mem_ctrl answers after lat cycles on a miss.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
        int l = line_of(a);
        bit exp_hit = model_hit(a);
        if_request = 1'b1;
        if_addr    = a;
        @(negedge clk);
        if (exp_hit) begin
            chk("hit_enable", if_enable, 32'd1);
            chk("hit_data", if_inst, m_word[l]);
            chk("hit_no_refill", mc_request, 32'd0);
        end else begin
            chk("miss_request", mc_request, 32'd1);
            chk("miss_addr", mc_addr, {a[31:2], 2'b00});
            chk("miss_no_enable", if_enable, 32'd0);
            repeat (lat) begin
                @(negedge clk);
                chk("miss_hold_req", mc_request, 32'd1);
                chk("miss_hold_en", if_enable, 32'd0);
            end
            mc_enable = 1'b1;
            mc_inst   = d;
            @(negedge clk);
            mc_enable = 1'b0;
            chk("fill_enable", if_enable, 32'd1);
            chk("fill_data", if_inst, d);
            chk("fill_req_clear", mc_request, 32'd0);
            if (!is_io(a)) begin
                m_line[l] = a[17:2];
                m_word[l] = d;
            end
        end
        // Request still held through the response cycle must not be taken again.
        @(negedge clk);
        chk("no_reaccept_en", if_enable, 32'd0);
        chk("no_reaccept_req", mc_request, 32'd0);
        if_request = 1'b0;
    endtask

    logic [31:0] pool [8];

    initial begin
        rst        = 1'b1;
        rdy        = 1'b1;
        failed     = 1'b0;
        if_request = 1'b0;
        if_addr    = '0;
        mc_inst    = '0;
        mc_enable  = 1'b0;
        #1;
        chk("rst_if_enable", if_enable, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mc_request", mc_request, 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss then hit.
        fetch(32'h0000_0100, 32'h0000_0013, 2);
        fetch(32'h0000_0100, 32'hDEAD_BEEF, 0);
        chk("warm_hit_model", {31'd0, model_hit(32'h0000_0100)}, 32'd1);

        // Conflict eviction on index 64.
        fetch(32'h0000_0300, 32'h1111_2222, 1);
        fetch(32'h0000_0100, 32'h3333_4444, 0);
        fetch(32'h0000_0100, 32'h0, 0);

        // I/O window: always a miss, never filled.
        fetch(32'h0003_0000, 32'hA0A0_0001, 0);
        fetch(32'h0003_0000, 32'hA0A0_0002, 1);
        fetch(32'h0003_0000, 32'hA0A0_0003, 0);

        // Flush two cycles into MISS.
        if_request = 1'b1;
        if_addr    = 32'h0000_0500;
        @(negedge clk);
        chk("flush_miss_req", mc_request, 32'd1);
        @(negedge clk);
        failed     = 1'b1;
        if_request = 1'b0;
        @(negedge clk);
        failed = 1'b0;
        chk("flush_req_clear", mc_request, 32'd0);
        chk("flush_no_enable", if_enable, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("flush_quiet_en", if_enable, 32'd0);
            chk("flush_quiet_req", mc_request, 32'd0);
        end
        fetch(32'h0000_0500, 32'h5555_0500, 1);

        // Flush coinciding with refill completion: line filled, no response.
        if_request = 1'b1;
        if_addr    = 32'h0000_0600;
        @(negedge clk);
        chk("flushfill_req", mc_request, 32'd1);
        failed     = 1'b1;
        mc_enable  = 1'b1;
        mc_inst    = 32'h6666_0600;
        if_request = 1'b0;
        @(negedge clk);
        failed    = 1'b0;
        mc_enable = 1'b0;
        chk("flushfill_no_en", if_enable, 32'd0);
        chk("flushfill_req_clr", mc_request, 32'd0);
        m_line[line_of(32'h600)] = 16'h0180;
        m_word[line_of(32'h600)] = 32'h6666_0600;
        fetch(32'h0000_0600, 32'h0, 0);

        // rdy low around mc_enable, then response after a live mc_enable.
        if_request = 1'b1;
        if_addr    = 32'h0000_0700;
        @(negedge clk);
        chk("rdy_miss_req", mc_request, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mc_enable = (i == 2);
            mc_inst   = 32'hBAD0_0000;
            @(negedge clk);
            chk("rdy_hold_req", mc_request, 32'd1);
            chk("rdy_hold_addr", mc_addr, 32'h0000_0700);
            chk("rdy_hold_en", if_enable, 32'd0);
        end
        mc_enable = 1'b0;
        rdy       = 1'b1;
        @(negedge clk);
        chk("rdy_ignored_req", mc_request, 32'd1);
        chk("rdy_ignored_en", if_enable, 32'd0);
        mc_enable = 1'b1;
        mc_inst   = 32'h7777_0700;
        @(negedge clk);
        mc_enable = 1'b0;
        chk("rdy_resp_en", if_enable, 32'd1);
        chk("rdy_resp_data", if_inst, 32'h7777_0700);
        m_line[line_of(32'h700)] = 16'h01C0;
        m_word[line_of(32'h700)] = 32'h7777_0700;
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rdy_freeze_en", if_enable, 32'd1);
            chk("rdy_freeze_data", if_inst, 32'h7777_0700);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("rdy_release_en", if_enable, 32'd0);
        if_request = 1'b0;
        @(negedge clk);

        // Randomised fetch stream over a small address pool with aliases and conflicts.
        pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0300; pool[2] = 32'h0000_4100;
        pool[3] = 32'h0000_0104; pool[4] = 32'h0000_01F0; pool[5] = 32'h0003_0100;
        pool[6] = 32'h0000_0500; pool[7] = 32'h0000_FFFC;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 7)];
            a[31:18] = 14'($urandom);
            a[1:0]   = 2'($urandom);
            fetch(a, $urandom, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a refill.
        fetch(32'h0000_0100, 32'h0100_0100, 0);
        if_request = 1'b1;
        if_addr    = 32'h0000_0904;
        @(negedge clk);
        chk("arst_miss_req", mc_request, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req_clear", mc_request, 32'd0);
        chk("arst_addr_clear", mc_addr, 32'd0);
        chk("arst_en_clear", if_enable, 32'd0);
        if_request = 1'b0;
        m_line.delete();
        m_word.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch(32'h0000_0100, 32'h0BAD_0100, 1);
        fetch(32'h0000_0100, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
